gs_imem_responder: RTL and testbench

Instruction-memory responder: the memory-side end of the prefetch fetch interface.
- Accepts word requests from the prefetch controller over a valid/ready handshake.
- Performs byte-masked writes (boot loader / test bench) or reads from an internal word-addressed SRAM model.
- Returns read data in order after a fixed pipeline latency, with backpressure and a flush for redirects.
- Sits between gs_prefetch_controller and the instruction store.

---
 rtl/gs_pkg.sv | 19 +
 rtl/gs_sync_fifo.sv | 58 +++++
 rtl/gs_imem_responder.sv | 139 +++++++++++++
 tb/tb_gs_imem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types and constants for the instruction-memory responder.
package gs_pkg;

    typedef enum logic [1:0] {
        RESET,
        IDLE,
        ACTIVE,
        FLUSH
    } gs_imem_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } gs_imem_rsp_t;

    localparam logic [3:0]  GS_IMEM_WEB_READ = 4'hF;
    localparam logic [31:0] GS_NOP_INSTR     = 32'h0000_0013;

endpackage

// File: rtl/gs_sync_fifo.sv
// Synchronous FIFO with flush; the output is the registered head entry, valid while not empty.
module gs_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/gs_imem_responder.sv
// Memory-side end of the prefetch fetch interface: byte-masked writes, in-order reads
// through a fixed-latency pipeline and a credit-bounded response queue, with flush.
module gs_imem_responder
    import gs_pkg::*;
#(
    parameter int DEPTH_WORDS     = 4096,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req_valid_i,
    output logic        im_req_ready_o,
    input  logic [31:0] im_addr_i,
    input  logic [3:0]  im_web_i,
    input  logic [31:0] im_wdata_i,
    output logic        im_rsp_valid_o,
    input  logic        im_rsp_ready_i,
    output logic [31:0] im_instr_o,
    output logic        im_rsp_err_o,
    input  logic        flush_i,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]          r_mem [DEPTH_WORDS];
    gs_imem_state_t       r_state;
    gs_imem_state_t       w_state_nxt;
    logic [CW-1:0]        r_count;
    logic [LATENCY-1:0]   r_pipe_vld;
    gs_imem_rsp_t         r_pipe_rsp [LATENCY];

    logic                 w_is_read;
    logic                 w_addr_err;
    logic [AW-1:0]        w_idx;
    logic                 w_acc;
    logic                 w_acc_rd;
    logic                 w_acc_wr;
    logic                 w_pop;
    gs_imem_rsp_t         w_rd_rsp;
    gs_imem_rsp_t         w_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_is_read  = (im_web_i == GS_IMEM_WEB_READ);
    assign w_addr_err = (im_addr_i[1:0] != 2'b00) || (im_addr_i[31:2] >= 30'(DEPTH_WORDS));
    assign w_idx      = im_addr_i[2 +: AW];
    assign w_acc      = im_req_valid_i && im_req_ready_o;
    assign w_acc_rd   = w_acc && w_is_read;
    assign w_acc_wr   = w_acc && !w_is_read && !w_addr_err;
    assign w_pop      = im_rsp_valid_o && im_rsp_ready_i;

    always_comb begin
        w_rd_rsp.instr = w_addr_err ? GS_NOP_INSTR : r_mem[w_idx];
        w_rd_rsp.err   = w_addr_err;
    end

    // Array is never reset so boot-loaded code survives a controller reset.
    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!im_web_i[b]) r_mem[w_idx][8*b +: 8] <= im_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_pipe_rsp[i] <= '0;
        end else if (flush_i) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_acc_rd;
            r_pipe_rsp[0] <= w_rd_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_rsp[i] <= r_pipe_rsp[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_count <= '0;
        else if (flush_i) r_count <= '0;
        else              r_count <= r_count + CW'(w_acc_rd) - CW'(w_pop);
    end

    // The credit count bounds queue occupancy, so the full guard never actually drops data.
    gs_sync_fifo #(
        .WIDTH ($bits(gs_imem_rsp_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pipe_vld[LATENCY-1] && !flush_i && !w_fifo_full),
        .i_data  (r_pipe_rsp[LATENCY-1]),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign im_rsp_valid_o = !w_fifo_empty;
    assign im_instr_o     = im_rsp_valid_o ? w_head.instr : '0;
    assign im_rsp_err_o   = im_rsp_valid_o ? w_head.err : 1'b0;

    // state: RESET=hold after reset | IDLE=no reads in flight | ACTIVE=reads outstanding | FLUSH=redirect drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RESET;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RESET:  w_state_nxt = IDLE;
            IDLE:   if (r_count != '0) w_state_nxt = ACTIVE;
            ACTIVE: begin
                if (flush_i)              w_state_nxt = FLUSH;
                else if (r_count == '0)   w_state_nxt = IDLE;
            end
            FLUSH:  w_state_nxt = IDLE;
            default: w_state_nxt = RESET;
        endcase
    end

    always_comb begin
        im_req_ready_o = 1'b0;
        if (r_state != RESET && !flush_i) begin
            im_req_ready_o = w_is_read ? (r_count < CW'(MAX_OUTSTANDING)) : 1'b1;
        end
        busy_o = (r_count != '0);
    end

endmodule

// File: tb/tb_gs_imem_responder.sv
// Directed bench for gs_imem_responder; expected responses are queued at acceptance and
// checked by an independent monitor when the DUT hands them over.
module tb_gs_imem_responder;
    import gs_pkg::*;

    logic        clk;
    logic        rst;
    logic        im_req_valid_i;
    logic        im_req_ready_o;
    logic [31:0] im_addr_i;
    logic [3:0]  im_web_i;
    logic [31:0] im_wdata_i;
    logic        im_rsp_valid_o;
    logic        im_rsp_ready_i;
    logic [31:0] im_instr_o;
    logic        im_rsp_err_o;
    logic        flush_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    gs_imem_rsp_t exp_q[$];
    gs_imem_rsp_t mon_e;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_instr = '0;
    logic         prev_err   = 1'b0;

    gs_imem_responder #(
        .DEPTH_WORDS     (4096),
        .LATENCY         (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_req_valid_i (im_req_valid_i),
        .im_req_ready_o (im_req_ready_o),
        .im_addr_i      (im_addr_i),
        .im_web_i       (im_web_i),
        .im_wdata_i     (im_wdata_i),
        .im_rsp_valid_o (im_rsp_valid_o),
        .im_rsp_ready_i (im_rsp_ready_i),
        .im_instr_o     (im_instr_o),
        .im_rsp_err_o   (im_rsp_err_o),
        .flush_i        (flush_i),
        .busy_o         (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (im_rsp_valid_o && im_rsp_ready_i) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_instr", im_instr_o, mon_e.instr);
                    check("rsp_err", 32'(im_rsp_err_o), 32'(mon_e.err));
                end
            end
            if (im_rsp_valid_o && !im_rsp_ready_i && prev_stall) begin
                check("hold_instr", im_instr_o, prev_instr);
                check("hold_err", 32'(im_rsp_err_o), 32'(prev_err));
            end
            prev_stall = im_rsp_valid_o && !im_rsp_ready_i;
            prev_instr = im_instr_o;
            prev_err   = im_rsp_err_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                         input logic [31:0] ei, input logic ee);
        logic acc;
        logic acc_now;
        gs_imem_rsp_t r;
        acc = 1'b0;
        im_req_valid_i = 1'b1;
        im_addr_i      = a;
        im_web_i       = w;
        im_wdata_i     = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc_now = im_req_ready_o;
            @(posedge clk);
            if (acc_now) begin
                acc = 1'b1;
                if (w == GS_IMEM_WEB_READ) begin
                    r.instr = ei;
                    r.err   = ee;
                    exp_q.push_back(r);
                end
            end
        end
        #1;
        im_req_valid_i = 1'b0;
        im_web_i       = GS_IMEM_WEB_READ;
        check("req_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (im_rsp_valid_o) begin
                lat = k;
                break;
            end
        end
        check(name, lat, 2);
    endtask

    initial begin
        rst            = 1'b1;
        im_req_valid_i = 1'b0;
        im_addr_i      = '0;
        im_web_i       = GS_IMEM_WEB_READ;
        im_wdata_i     = '0;
        im_rsp_ready_i = 1'b1;
        flush_i        = 1'b0;

        #3;
        check("rst_ready", 32'(im_req_ready_o), 0);
        check("rst_valid", 32'(im_rsp_valid_o), 0);
        check("rst_instr", im_instr_o, 0);
        check("rst_err", 32'(im_rsp_err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_ready_lo", 32'(im_req_ready_o), 0);
        @(negedge clk);
        check("rel_ready_hi", 32'(im_req_ready_o), 1);
        @(posedge clk);
        #1;

        // Full write then read with latency measurement.
        issue(32'h100, 4'h0, 32'hDEADBEEF, '0, 1'b0);
        issue(32'h100, GS_IMEM_WEB_READ, '0, 32'hDEADBEEF, 1'b0);
        check("busy_after_rd", 32'(busy_o), 1);
        measure_latency("latency_first");
        wait_drain();
        check("busy_idle", 32'(busy_o), 0);

        // Partial write and write-then-read on adjacent cycles.
        issue(32'h104, 4'h0, 32'hFFFFFFFF, '0, 1'b0);
        issue(32'h104, 4'b1100, 32'h0000_1234, '0, 1'b0);
        issue(32'h104, GS_IMEM_WEB_READ, '0, 32'hFFFF_1234, 1'b0);
        issue(32'h108, 4'h0, 32'hCAFEF00D, '0, 1'b0);
        issue(32'h108, GS_IMEM_WEB_READ, '0, 32'hCAFEF00D, 1'b0);
        wait_drain();

        // Error addresses, dropped out-of-range write, last legal word.
        issue(32'h0, 4'h0, 32'h1111_1111, '0, 1'b0);
        issue(32'h102, GS_IMEM_WEB_READ, '0, GS_NOP_INSTR, 1'b1);
        issue(32'h4000, GS_IMEM_WEB_READ, '0, GS_NOP_INSTR, 1'b1);
        issue(32'h4000, 4'h0, 32'h5555_5555, '0, 1'b0);
        issue(32'h0, GS_IMEM_WEB_READ, '0, 32'h1111_1111, 1'b0);
        issue(32'h3FFC, 4'h0, 32'hA5A5_A5A5, '0, 1'b0);
        issue(32'h3FFC, GS_IMEM_WEB_READ, '0, 32'hA5A5_A5A5, 1'b0);
        wait_drain();

        // Credit limit with backpressure.
        im_rsp_ready_i = 1'b0;
        issue(32'h100, GS_IMEM_WEB_READ, '0, 32'hDEADBEEF, 1'b0);
        issue(32'h104, GS_IMEM_WEB_READ, '0, 32'hFFFF_1234, 1'b0);
        im_req_valid_i = 1'b1;
        im_addr_i      = 32'h0;
        im_web_i       = GS_IMEM_WEB_READ;
        @(negedge clk);
        check("ready_at_credit", 32'(im_req_ready_o), 0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_at_credit", 32'(busy_o), 1);
        im_rsp_ready_i = 1'b1;
        @(negedge clk);
        check("ready_pop_cycle", 32'(im_req_ready_o), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_pop", 32'(im_req_ready_o), 1);
        @(posedge clk);
        mon_e.instr = 32'h1111_1111;
        mon_e.err   = 1'b0;
        exp_q.push_back(mon_e);
        #1;
        im_req_valid_i = 1'b0;
        wait_drain();

        // Flush with two reads queued.
        im_rsp_ready_i = 1'b0;
        issue(32'h100, GS_IMEM_WEB_READ, '0, 32'hDEADBEEF, 1'b0);
        issue(32'h104, GS_IMEM_WEB_READ, '0, 32'hFFFF_1234, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        flush_i        = 1'b1;
        im_req_valid_i = 1'b1;
        im_addr_i      = 32'h100;
        @(negedge clk);
        check("ready_in_flush", 32'(im_req_ready_o), 0);
        @(posedge clk);
        exp_q.delete();
        #1;
        flush_i        = 1'b0;
        im_req_valid_i = 1'b0;
        check("flush_valid", 32'(im_rsp_valid_o), 0);
        check("flush_busy", 32'(busy_o), 0);
        im_rsp_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("quiet_after_flush", 32'(im_rsp_valid_o), 0);
        issue(32'h104, GS_IMEM_WEB_READ, '0, 32'hFFFF_1234, 1'b0);
        measure_latency("latency_after_flush");
        wait_drain();

        // Reset with two reads queued.
        im_rsp_ready_i = 1'b0;
        issue(32'h100, GS_IMEM_WEB_READ, '0, 32'hDEADBEEF, 1'b0);
        issue(32'h104, GS_IMEM_WEB_READ, '0, 32'hFFFF_1234, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_valid", 32'(im_rsp_valid_o), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(im_rsp_valid_o), 0);
        check("async_rst_instr", im_instr_o, 0);
        check("async_rst_err", 32'(im_rsp_err_o), 0);
        check("async_rst_busy", 32'(busy_o), 0);
        check("async_rst_ready", 32'(im_req_ready_o), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel2_ready_lo", 32'(im_req_ready_o), 0);
        @(negedge clk);
        check("rel2_ready_hi", 32'(im_req_ready_o), 1);
        @(posedge clk);
        #1;
        im_rsp_ready_i = 1'b1;
        issue(32'h100, GS_IMEM_WEB_READ, '0, 32'hDEADBEEF, 1'b0);
        wait_drain();
        check("final_busy", 32'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
